serial_hba_bridge: RTL and testbench

- Second-generation bridge from a host serial byte stream to the HBA bus master interface.
- Sits between a UART core (byte streams with valid/ready) and the HBA bus arbiter.
- Adds over the first generation: multi-byte data width, multi-byte register address, 1..MAX_BURST bursts, non-incrementing (FIFO) mode, bus-timeout NACK, header resync timeout, and a status byte for every command.

---
 rtl/serial_hba_pkg.sv | 34 +++
 rtl/hba_xfer.sv | 106 ++++++++++
 rtl/serial_hba_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_serial_hba_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_hba_pkg.sv
// Shared types and constants for the serial-to-HBA bridge.
// Imported by the bridge top and its bus transaction engine.
package serial_hba_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LEN,
        S_HDR_ADDR,
        S_WR_DATA,
        S_BUS,
        S_RD_SEND,
        S_FILL,
        S_DRAIN,
        S_STATUS
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_REQ,
        X_SEL
    } xstate_t;

    localparam logic [7:0] ST_ACK          = 8'hAC;
    localparam logic [7:0] ST_NACK_TIMEOUT = 8'h56;
    localparam logic [7:0] ST_NACK_LEN     = 8'h57;

    localparam int CMD_RNW   = 7;
    localparam int CMD_NOINC = 6;

    function automatic int bytes_of(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/hba_xfer.sv
// One HBA bus transaction: request, grant, select, ack capture and timeout.
// Caller holds addr/rnw/wdata stable from start until done or timeout.
module hba_xfer
    import serial_hba_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DBUS_WIDTH  = 8,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rnw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DBUS_WIDTH-1:0] wdata,
    input  logic                  hba_mgrant,
    input  logic                  hba_xferack,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic                  master_request,
    output logic [ADDR_WIDTH-1:0] master_abus,
    output logic                  master_rnw,
    output logic                  master_select,
    output logic [DBUS_WIDTH-1:0] master_dbus,
    output logic                  idle,
    output logic                  done,
    output logic                  timeout,
    output logic [DBUS_WIDTH-1:0] rdata
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(BUS_TIMEOUT - 1);

    xstate_t               xs_q, xs_d;
    logic [ADDR_WIDTH-1:0] abus_q, abus_d;
    logic [DBUS_WIDTH-1:0] dbus_q, dbus_d;
    logic [DBUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rnw_q, rnw_d;
    logic [TW-1:0]         timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q    <= X_IDLE;
            abus_q  <= '0;
            dbus_q  <= '0;
            rdata_q <= '0;
            rnw_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            xs_q    <= xs_d;
            abus_q  <= abus_d;
            dbus_q  <= dbus_d;
            rdata_q <= rdata_d;
            rnw_q   <= rnw_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        xs_d    = xs_q;
        abus_d  = abus_q;
        dbus_d  = dbus_q;
        rdata_d = rdata_q;
        rnw_d   = rnw_q;
        timer_d = timer_q;
        done    = 1'b0;
        timeout = 1'b0;
        unique case (xs_q)
            X_IDLE: begin
                if (start) xs_d = X_REQ;
            end
            X_REQ: begin
                if (hba_mgrant) begin
                    abus_d  = addr;
                    dbus_d  = rnw ? '0 : wdata;
                    rnw_d   = rnw;
                    timer_d = '0;
                    xs_d    = X_SEL;
                end
            end
            X_SEL: begin
                // An ack arriving on the expiry cycle still wins.
                if (hba_xferack || timer_q == T_LAST) begin
                    done    = hba_xferack;
                    timeout = !hba_xferack;
                    if (hba_xferack && rnw_q) rdata_d = hba_dbus;
                    abus_d  = '0;
                    dbus_d  = '0;
                    rnw_d   = 1'b0;
                    xs_d    = X_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: xs_d = X_IDLE;
        endcase
    end

    assign master_request = (xs_q != X_IDLE);
    assign master_select  = (xs_q == X_SEL);
    assign master_abus    = abus_q;
    assign master_dbus    = dbus_q;
    assign master_rnw     = rnw_q;
    assign idle           = (xs_q == X_IDLE);
    assign rdata          = rdata_q;

endmodule

// File: rtl/serial_hba_bridge.sv
// Host serial byte stream to HBA bus master: header parse, bursts,
// length/timeout NACKs, header resync and a status byte per command.
module serial_hba_bridge
    import serial_hba_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int MAX_BURST         = 16,
    parameter int BUS_TIMEOUT       = 1024,
    parameter int RX_IDLE_TIMEOUT   = 100000
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  hba_mgrant,
    input  logic                  hba_xferack,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic                  master_request,
    output logic [ADDR_WIDTH-1:0] master_abus,
    output logic                  master_rnw,
    output logic                  master_select,
    output logic [DBUS_WIDTH-1:0] master_dbus,
    output logic                  intr
);

    localparam int NB = bytes_of(DBUS_WIDTH);
    localparam int NA = bytes_of(REG_ADDR_WIDTH);
    localparam int IW = $clog2(RX_IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(RX_IDLE_TIMEOUT - 1);

    state_t                         state_q, state_d;
    logic                           rnw_q, rnw_d;
    logic                           noinc_q, noinc_d;
    logic [PERIPH_ADDR_WIDTH-1:0]   periph_q, periph_d;
    logic [8:0]                     cnt_q, cnt_d;
    logic [NA*8-1:0]                areg_q, areg_d;
    logic [7:0]                     aidx_q, aidx_d;
    logic [7:0]                     bidx_q, bidx_d;
    logic [DBUS_WIDTH-1:0]          wdata_q, wdata_d;
    logic [23:0]                    rem_q, rem_d;
    logic [7:0]                     status_q, status_d;
    logic                           intr_q, intr_d;
    logic [IW-1:0]                  idle_q, idle_d;
    logic                           live_q, live_d;

    logic                  rx_ready_c;
    logic                  rx_fire;
    logic                  x_start, x_idle, x_done, x_timeout;
    logic [DBUS_WIDTH-1:0] x_rdata;
    logic [ADDR_WIDTH-1:0] x_addr;

    assign rx_ready = rx_ready_c & live_q;
    assign rx_fire  = rx_valid & rx_ready;
    assign intr     = intr_q;
    assign x_addr   = {periph_q, areg_q[REG_ADDR_WIDTH-1:0]};
    assign x_start  = (state_q == S_BUS) && x_idle;

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_q  <= S_IDLE;
            rnw_q    <= 1'b0;
            noinc_q  <= 1'b0;
            periph_q <= '0;
            cnt_q    <= '0;
            areg_q   <= '0;
            aidx_q   <= '0;
            bidx_q   <= '0;
            wdata_q  <= '0;
            rem_q    <= '0;
            status_q <= '0;
            intr_q   <= 1'b0;
            idle_q   <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            noinc_q  <= noinc_d;
            periph_q <= periph_d;
            cnt_q    <= cnt_d;
            areg_q   <= areg_d;
            aidx_q   <= aidx_d;
            bidx_q   <= bidx_d;
            wdata_q  <= wdata_d;
            rem_q    <= rem_d;
            status_q <= status_d;
            intr_q   <= intr_d;
            idle_q   <= idle_d;
            live_q   <= live_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rnw_d      = rnw_q;
        noinc_d    = noinc_q;
        periph_d   = periph_q;
        cnt_d      = cnt_q;
        areg_d     = areg_q;
        aidx_d     = aidx_q;
        bidx_d     = bidx_q;
        wdata_d    = wdata_q;
        rem_d      = rem_q;
        status_d   = status_q;
        intr_d     = intr_q;
        idle_d     = '0;
        live_d     = 1'b1;
        rx_ready_c = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    rnw_d    = rx_data[CMD_RNW];
                    noinc_d  = rx_data[CMD_NOINC];
                    periph_d = rx_data[PERIPH_ADDR_WIDTH-1:0];
                    intr_d   = 1'b0;
                    state_d  = S_HDR_LEN;
                end
            end
            S_HDR_LEN, S_HDR_ADDR: begin
                rx_ready_c = 1'b1;
                if (rx_fire && state_q == S_HDR_LEN) begin
                    cnt_d   = 9'(rx_data) + 9'd1;
                    aidx_d  = '0;
                    state_d = S_HDR_ADDR;
                end else if (rx_fire) begin
                    areg_d[{aidx_q, 3'b000} +: 8] = rx_data;
                    aidx_d = aidx_q + 8'd1;
                    bidx_d = '0;
                    if (aidx_q == 8'(NA - 1)) begin
                        if (cnt_q > 9'(MAX_BURST)) begin
                            status_d = ST_NACK_LEN;
                            intr_d   = 1'b1;
                            rem_d    = 24'(cnt_q) * 24'(NB);
                            state_d  = rnw_q ? S_STATUS : S_DRAIN;
                        end else begin
                            state_d = rnw_q ? S_BUS : S_WR_DATA;
                        end
                    end
                end else if (idle_q == IDLE_LAST) begin
                    intr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            S_WR_DATA: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    wdata_d[{bidx_q, 3'b000} +: 8] = rx_data;
                    bidx_d = bidx_q + 8'd1;
                    if (bidx_q == 8'(NB - 1)) begin
                        bidx_d  = '0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (x_done) begin
                    cnt_d = cnt_q - 9'd1;
                    if (!noinc_q) begin
                        areg_d[REG_ADDR_WIDTH-1:0] =
                            areg_q[REG_ADDR_WIDTH-1:0] + REG_ADDR_WIDTH'(1);
                    end
                    status_d = ST_ACK;
                    if (rnw_q) state_d = S_RD_SEND;
                    else if (cnt_q == 9'd1) state_d = S_STATUS;
                    else state_d = S_WR_DATA;
                end else if (x_timeout) begin
                    intr_d   = 1'b1;
                    status_d = ST_NACK_TIMEOUT;
                    // Reads still owe the failed word; writes already took it.
                    if (rnw_q) begin
                        rem_d   = 24'(cnt_q) * 24'(NB);
                        state_d = S_FILL;
                    end else begin
                        rem_d   = 24'(cnt_q - 9'd1) * 24'(NB);
                        state_d = (cnt_q == 9'd1) ? S_STATUS : S_DRAIN;
                    end
                end
            end
            S_RD_SEND: begin
                tx_valid = 1'b1;
                tx_data  = x_rdata[{bidx_q, 3'b000} +: 8];
                if (tx_ready) begin
                    bidx_d = bidx_q + 8'd1;
                    if (bidx_q == 8'(NB - 1)) begin
                        bidx_d  = '0;
                        state_d = (cnt_q == 9'd0) ? S_STATUS : S_BUS;
                    end
                end
            end
            S_FILL: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    rem_d = rem_q - 24'd1;
                    if (rem_q == 24'd1) state_d = S_STATUS;
                end
            end
            S_DRAIN: begin
                rx_ready_c = 1'b1;
                if (rx_fire) begin
                    rem_d = rem_q - 24'd1;
                    if (rem_q == 24'd1) state_d = S_STATUS;
                end
            end
            S_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    hba_xfer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DBUS_WIDTH  (DBUS_WIDTH),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_xfer (
        .clk            (hba_clk),
        .rst_n          (hba_reset_n),
        .start          (x_start),
        .rnw            (rnw_q),
        .addr           (x_addr),
        .wdata          (wdata_q),
        .hba_mgrant     (hba_mgrant),
        .hba_xferack    (hba_xferack),
        .hba_dbus       (hba_dbus),
        .master_request (master_request),
        .master_abus    (master_abus),
        .master_rnw     (master_rnw),
        .master_select  (master_select),
        .master_dbus    (master_dbus),
        .idle           (x_idle),
        .done           (x_done),
        .timeout        (x_timeout),
        .rdata          (x_rdata)
    );

endmodule

// File: tb/tb_serial_hba_bridge.sv
// Directed bench for serial_hba_bridge with tx/bus scoreboards
// and a small HBA slave model.
module tb_serial_hba_bridge;

    localparam int BT  = 64;
    localparam int RIT = 200;

    typedef struct packed {
        logic [11:0] abus;
        logic        rnw;
        logic [7:0]  dbus;
    } bus_t;

    logic        hba_clk = 1'b0;
    logic        hba_reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        hba_mgrant = 1'b0;
    logic        hba_xferack = 1'b0;
    logic [7:0]  hba_dbus = 8'h00;
    logic        master_request;
    logic [11:0] master_abus;
    logic        master_rnw;
    logic        master_select;
    logic [7:0]  master_dbus;
    logic        intr;
    logic [33:0] outs;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];
    logic [7:0] rd_q[$];
    int xfer_no = 0;
    int hold_no = -1;
    int sel_cnt = 0;
    int last_sel_len = 0;
    logic sel_prev = 1'b0;
    logic tx_pend = 1'b0;
    logic [7:0] tx_pend_data = 8'h00;

    serial_hba_bridge #(
        .BUS_TIMEOUT     (BT),
        .RX_IDLE_TIMEOUT (RIT)
    ) dut (
        .hba_clk        (hba_clk),
        .hba_reset_n    (hba_reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .hba_mgrant     (hba_mgrant),
        .hba_xferack    (hba_xferack),
        .hba_dbus       (hba_dbus),
        .master_request (master_request),
        .master_abus    (master_abus),
        .master_rnw     (master_rnw),
        .master_select  (master_select),
        .master_dbus    (master_dbus),
        .intr           (intr)
    );

    assign outs = {rx_ready, tx_valid, tx_data, master_request, master_abus,
                   master_rnw, master_select, master_dbus, intr};

    always #5 hba_clk = ~hba_clk;

    task automatic check(input string tag, input logic [33:0] got,
                         input logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave, bus monitor and tx sink share one process to stay race-free.
    always @(negedge hba_clk) begin
        if (!hba_reset_n) begin
            hba_mgrant  = 1'b0;
            hba_xferack = 1'b0;
            sel_prev    = 1'b0;
            tx_pend     = 1'b0;
        end else begin
            if (master_select && !sel_prev) begin
                bus_t e;
                xfer_no++;
                sel_cnt = 0;
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected", 34'(master_abus), 34'h3ffff);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_abus", 34'(master_abus), 34'(e.abus));
                    check("bus_rnw", 34'(master_rnw), 34'(e.rnw));
                    if (!e.rnw) check("bus_dbus", 34'(master_dbus), 34'(e.dbus));
                end
            end
            if (!master_select && sel_prev) last_sel_len = sel_cnt;
            if (!master_select)
                check("bus_idle_zero", 34'({master_abus, master_dbus}), 34'd0);
            if (master_select) sel_cnt++;
            sel_prev = master_select;

            hba_mgrant = master_request && !master_select;
            if (master_select && xfer_no != hold_no && sel_cnt == 2) begin
                hba_xferack = 1'b1;
                if (master_rnw && rd_q.size() > 0) hba_dbus = rd_q.pop_front();
            end else begin
                hba_xferack = 1'b0;
            end

            if (tx_pend)
                check("tx_hold", 34'({tx_valid, tx_data}), 34'({1'b1, tx_pend_data}));
            tx_ready = ($urandom_range(0, 3) != 0);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0)
                    check("tx_unexpected", 34'(tx_data), 34'h3ffff);
                else
                    check("tx_byte", 34'(tx_data), 34'(exp_tx.pop_front()));
            end
            tx_pend      = tx_valid && !tx_ready;
            tx_pend_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(negedge hba_clk);
            n++;
        end
        check("rx_accept_bound", 34'(n < 2000), 34'd1);
        @(negedge hba_clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            @(negedge hba_clk);
            n++;
        end
        check("done_bound", 34'(n < 3000), 34'd1);
        repeat (3) @(negedge hba_clk);
    endtask

    function automatic bus_t bx(input logic [11:0] a, input logic r,
                                input logic [7:0] d);
        bus_t t;
        t.abus = a;
        t.rnw  = r;
        t.dbus = d;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        check("reset_outputs", outs, 34'd0);
        repeat (3) @(negedge hba_clk);
        check("reset_outputs_held", outs, 34'd0);
        hba_reset_n = 1'b1;
        repeat (2) @(negedge hba_clk);
        check("idle_rx_ready", 34'(rx_ready), 34'd1);

        // single write
        exp_bus.push_back(bx(12'h310, 1'b0, 8'h5A));
        exp_tx.push_back(8'hAC);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h5A);
        wait_done();
        check("wr1_intr", 34'(intr), 34'd0);

        // read burst with register wrap
        exp_bus.push_back(bx(12'h2FE, 1'b1, 8'h00));
        exp_bus.push_back(bx(12'h2FF, 1'b1, 8'h00));
        exp_bus.push_back(bx(12'h200, 1'b1, 8'h00));
        rd_q = '{8'h11, 8'h22, 8'h33};
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'hAC};
        send_byte(8'h82); send_byte(8'h02); send_byte(8'hFE);
        wait_done();

        // non-incrementing write burst
        for (int i = 0; i < 4; i++) exp_bus.push_back(bx(12'h540, 1'b0, 8'hA1 + 8'(i)));
        exp_tx.push_back(8'hAC);
        send_byte(8'h45); send_byte(8'h03); send_byte(8'h40);
        for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i));
        wait_done();

        // read burst, second transfer never acked
        hold_no = xfer_no + 2;
        exp_bus.push_back(bx(12'h120, 1'b1, 8'h00));
        exp_bus.push_back(bx(12'h121, 1'b1, 8'h00));
        rd_q = '{8'h77};
        exp_tx = '{8'h77, 8'h00, 8'h00, 8'h56};
        send_byte(8'h81); send_byte(8'h02); send_byte(8'h20);
        wait_done();
        hold_no = -1;
        check("timeout_sel_len", 34'(last_sel_len), 34'(BT));
        check("timeout_intr", 34'(intr), 34'd1);

        // over-long write drained
        send_byte(8'h01);
        check("cmd_clears_intr", 34'(intr), 34'd0);
        exp_tx.push_back(8'h57);
        send_byte(8'h1F); send_byte(8'h00);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        wait_done();
        check("len_nack_intr", 34'(intr), 34'd1);
        check("len_nack_no_bus", 34'(xfer_no), 34'd10);

        // header resync
        send_byte(8'h02);
        check("resync_cmd_clears_intr", 34'(intr), 34'd0);
        repeat (RIT - 20) @(negedge hba_clk);
        check("resync_not_early", 34'(intr), 34'd0);
        n = 0;
        while (!intr && n < 60) begin
            @(negedge hba_clk);
            n++;
        end
        check("resync_intr", 34'(intr), 34'd1);
        exp_bus.push_back(bx(12'h233, 1'b0, 8'hC3));
        exp_tx.push_back(8'hAC);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h33); send_byte(8'hC3);
        wait_done();

        // reset while select is high
        hold_no = xfer_no + 1;
        exp_bus.push_back(bx(12'h3AA, 1'b0, 8'h99));
        send_byte(8'h03); send_byte(8'h00); send_byte(8'hAA); send_byte(8'h99);
        n = 0;
        while (!master_select && n < 100) begin
            @(negedge hba_clk);
            n++;
        end
        check("pre_reset_select", 34'(master_select), 34'd1);
        #2 hba_reset_n = 1'b0;
        #1 check("async_reset_outputs", outs, 34'd0);
        @(negedge hba_clk);
        hold_no = -1;
        hba_reset_n = 1'b1;
        repeat (2) @(negedge hba_clk);

        // single read after reset
        exp_bus.push_back(bx(12'h407, 1'b1, 8'h00));
        rd_q = '{8'hE5};
        exp_tx = '{8'hE5, 8'hAC};
        send_byte(8'h84); send_byte(8'h00); send_byte(8'h07);
        wait_done();
        check("final_rd_q_empty", 34'(rd_q.size()), 34'd0);
        check("final_intr", 34'(intr), 34'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
